// File: rtl/electronic_lock.sv
// Two-button sequential combination lock with overlap-aware progress fallback.
// Optional idle auto-relock from OPEN is enabled by ELECTRONIC_LOCK_AUTO_RELOCK_EN.
module electronic_lock #(
  parameter int unsigned CODE_LEN      = 4,
  parameter logic [6:0]  CODE          = 7'b0001101,
  parameter int unsigned RELOCK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b0,
  input  logic       b1,
  output logic       unlc,
  output logic [2:0] st
);

  localparam logic [7:0] CodeW   = {1'b0, CODE};
  localparam logic [2:0] OpenSt  = 3'(CODE_LEN);

  // Next progress for a press of digit d at progress p. When p == CODE_LEN the
  // fallback is limited to a proper prefix so that any press leaves OPEN.
  function automatic logic [2:0] calc_next(input int unsigned p, input logic d);
    logic [7:0]  cur;
    logic [7:0]  msk;
    logic [7:0]  seq;
    logic [7:0]  sfx;
    int unsigned best;
    cur = CodeW >> p;
    if (p < CODE_LEN && d == cur[0]) begin
      return 3'(p + 1);
    end
    msk  = (8'd1 << p) - 8'd1;
    seq  = (CodeW & msk) | (8'(d) << p);
    best = 0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (k <= p && k < CODE_LEN) begin
        msk = (8'd1 << k) - 8'd1;
        sfx = (seq >> (p + 1 - k)) & msk;
        if (sfx == (CodeW & msk)) best = k;
      end
    end
    return 3'(best);
  endfunction

  logic [2:0] nxt0_tbl [8];
  logic [2:0] nxt1_tbl [8];

  for (genvar g = 0; g < 8; g++) begin : g_tbl
    if (g <= CODE_LEN) begin : g_used
      assign nxt0_tbl[g] = calc_next(g, 1'b0);
      assign nxt1_tbl[g] = calc_next(g, 1'b1);
    end else begin : g_unused
      assign nxt0_tbl[g] = 3'd0;
      assign nxt1_tbl[g] = 3'd0;
    end
  end

  logic [2:0] st_q, st_d;
  logic       unlc_q, unlc_d;

`ifdef ELECTRONIC_LOCK_AUTO_RELOCK_EN
  localparam logic [7:0] RelockW = 8'(RELOCK_CYCLES);
  logic [7:0] cnt_q, cnt_d;
`endif

  always_comb begin
    st_d = st_q;
    unique case ({b1, b0})
      2'b10:   st_d = nxt1_tbl[st_q];
      2'b01:   st_d = nxt0_tbl[st_q];
      2'b11:   st_d = 3'd0;
      default: st_d = st_q;
    endcase
`ifdef ELECTRONIC_LOCK_AUTO_RELOCK_EN
    cnt_d = 8'd0;
    if (!b0 && !b1 && st_q == OpenSt) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == RelockW) begin
        st_d  = 3'd0;
        cnt_d = 8'd0;
      end
    end
`endif
    unlc_d = (st_d == OpenSt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= 3'd0;
      unlc_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      unlc_q <= unlc_d;
    end
  end

`ifdef ELECTRONIC_LOCK_AUTO_RELOCK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign st   = st_q;
  assign unlc = unlc_q;

endmodule

// File: tb/tb_electronic_lock.sv
// Directed self-checking bench for electronic_lock with default code 1,0,1,1.
module tb_electronic_lock;

  logic       clk;
  logic       rst;
  logic       b0;
  logic       b1;
  logic       unlc;
  logic [2:0] st;

  int total;
  int bad;

  electronic_lock dut (
    .clk  (clk),
    .rst  (rst),
    .b0   (b0),
    .b1   (b1),
    .unlc (unlc),
    .st   (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive {b1,b0} for one edge, then settle just after it.
  task automatic step(input logic v1, input logic v0);
    @(negedge clk);
    b1 = v1;
    b0 = v0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    b0  = 1'b0;
    b1  = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    b0  = 1'b0;
    b1  = 1'b0;
    rst = 1'b0;
    #2;
    total++;
    if ({unlc, st} !== 4'b0_000) begin
      bad++;
      $display("FAIL reset_initial got unlc=%b st=%0d want unlc=0 st=0", unlc, st);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    total++;
    if ({unlc, st} !== 4'b0_010) begin
      bad++;
      $display("FAIL reset_pre got unlc=%b st=%0d want unlc=0 st=2", unlc, st);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({unlc, st} !== 4'b0_000) begin
      bad++;
      $display("FAIL reset_async got unlc=%b st=%0d want unlc=0 st=0", unlc, st);
    end
    @(negedge clk);
    b0  = 1'b0;
    rst = 1'b1;
    step(1'b1, 1'b0);
    total++;
    if ({unlc, st} !== 4'b0_001) begin
      bad++;
      $display("FAIL reset_resume got unlc=%b st=%0d want unlc=0 st=1", unlc, st);
    end
  endtask

  task automatic test_correct();
    logic [1:0] keys [4] = '{2'b10, 2'b01, 2'b10, 2'b10};
    logic [3:0] exp  [4] = '{4'b0_001, 4'b0_010, 4'b0_011, 4'b1_100};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(keys[i][1], keys[i][0]);
      total++;
      if ({unlc, st} !== exp[i]) begin
        bad++;
        $display("FAIL correct[%0d] got unlc=%b st=%0d want %b", i, unlc, st, exp[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      total++;
      if ({unlc, st} !== 4'b1_100) begin
        bad++;
        $display("FAIL correct_hold[%0d] got unlc=%b st=%0d want unlc=1 st=4", i, unlc, st);
      end
    end
  endtask

  task automatic test_overlap();
    logic [1:0] keys [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
    logic [3:0] exp  [6] = '{4'b0_001, 4'b0_010, 4'b0_011, 4'b0_010, 4'b0_011, 4'b1_100};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(keys[i][1], keys[i][0]);
      total++;
      if ({unlc, st} !== exp[i]) begin
        bad++;
        $display("FAIL overlap[%0d] got unlc=%b st=%0d want %b", i, unlc, st, exp[i]);
      end
    end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      total++;
      if ({unlc, st} !== 4'b0_001) begin
        bad++;
        $display("FAIL overlap_11[%0d] got unlc=%b st=%0d want unlc=0 st=1", i, unlc, st);
      end
    end
  endtask

  task automatic test_relock();
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    total++;
    if ({unlc, st} !== 4'b0_010) begin
      bad++;
      $display("FAIL relock_press0 got unlc=%b st=%0d want unlc=0 st=2", unlc, st);
    end
    step(1'b1, 1'b0);
    total++;
    if ({unlc, st} !== 4'b0_011) begin
      bad++;
      $display("FAIL relock_p1 got unlc=%b st=%0d want unlc=0 st=3", unlc, st);
    end
    step(1'b1, 1'b0);
    total++;
    if ({unlc, st} !== 4'b1_100) begin
      bad++;
      $display("FAIL relock_reopen got unlc=%b st=%0d want unlc=1 st=4", unlc, st);
    end
  endtask

  task automatic test_invalid();
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    total++;
    if ({unlc, st} !== 4'b0_011) begin
      bad++;
      $display("FAIL invalid_pre got unlc=%b st=%0d want unlc=0 st=3", unlc, st);
    end
    step(1'b1, 1'b1);
    total++;
    if ({unlc, st} !== 4'b0_000) begin
      bad++;
      $display("FAIL invalid_both got unlc=%b st=%0d want unlc=0 st=0", unlc, st);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      total++;
      if ({unlc, st} !== 4'b0_010) begin
        bad++;
        $display("FAIL idle_hold[%0d] got unlc=%b st=%0d want unlc=0 st=2", i, unlc, st);
      end
    end
    // Invalid input from OPEN also relocks.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    total++;
    if ({unlc, st} !== 4'b0_000) begin
      bad++;
      $display("FAIL invalid_open got unlc=%b st=%0d want unlc=0 st=0", unlc, st);
    end
  endtask

  task automatic test_auto_relock();
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
`ifdef ELECTRONIC_LOCK_AUTO_RELOCK_EN
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    total++;
    if ({unlc, st} !== 4'b1_100) begin
      bad++;
      $display("FAIL auto_idle7 got unlc=%b st=%0d want unlc=1 st=4", unlc, st);
    end
    step(1'b0, 1'b0);
    total++;
    if ({unlc, st} !== 4'b0_000) begin
      bad++;
      $display("FAIL auto_idle8 got unlc=%b st=%0d want unlc=0 st=0", unlc, st);
    end
`else
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    total++;
    if ({unlc, st} !== 4'b1_100) begin
      bad++;
      $display("FAIL no_auto_idle20 got unlc=%b st=%0d want unlc=1 st=4", unlc, st);
    end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_correct();
    test_overlap();
    test_relock();
    test_invalid();
    test_auto_relock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/electronic_lock.md
Name: electronic_lock

Overview:
- Two-button sequential combination lock: button b1 enters digit 1, button b0 enters digit 0.
- Button state is sampled once per rising clock edge and compared against a parameterised secret code.
- Completing the code drives the unlock output; the 3-bit progress state is exported for status and debug.
- Sits between debounced, clock-synchronous button inputs and the actuator/indicator logic.

Parameters:
- CODE_LEN, 4, number of digits in the code; legal range 1..7 (st is 3 bits).
- CODE, 7'b0001101, code digits; CODE[i] is the i-th press (i=0 first). The default is the sequence 1,0,1,1. Bits at CODE_LEN and above are ignored.
- RELOCK_CYCLES, 8, idle cycles in OPEN before auto-relock; used only with the optional feature; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-low.
- b0  input  1  digit-0 button, synchronous to clk, level-sampled each edge.
- b1  input  1  digit-1 button, synchronous to clk, level-sampled each edge.
- unlc  output  1  registered unlock indication; 1 while the lock is open.
- st  output  3  registered progress state: number of code digits currently matched, 0..CODE_LEN.

Behaviour:
- Reset:
  - rst=0 asynchronously forces st=0 and unlc=0, regardless of clk.
  - Normal operation resumes on the first rising edge after rst returns to 1.
  - Asserting reset mid-sequence discards all progress.
- Input decode, per rising edge:
  - b1=1, b0=0: press of digit 1.
  - b0=1, b1=0: press of digit 0.
  - b0=0, b1=0: idle. st and unlc hold.
  - b0=1, b1=1: invalid. st goes to 0 and unlc to 0 on that edge.
- On a press of digit d with current progress p (0..CODE_LEN):
  - If p<CODE_LEN and d==CODE[p], next st = p+1.
  - Otherwise, next st = the length of the longest proper suffix of the sequence (CODE[0..p-1], d) that equals a prefix of CODE. This is overlap-aware fallback, precomputed per state and digit; a combinational table or generate loop is acceptable.
  - When p==CODE_LEN (OPEN), any press relocks and uses the same fallback rule with the full code as the matched prefix.
- States: 0..CODE_LEN-1 are LOCKED with progress p; CODE_LEN is OPEN.
- unlc is 1 exactly when the registered st equals CODE_LEN. It is updated on the same edge as st, so unlc rises on the edge that samples the final correct digit, with zero added latency.
- unlc stays high through idle cycles, and drops on the edge that samples any press or an invalid input.
- st never exceeds CODE_LEN. No wrap-around.
- There are no other outputs and no handshake; one press is consumed per cycle in which a button is held. A held button counts as repeated presses.

Optional Feature:
- Macro: ELECTRONIC_LOCK_AUTO_RELOCK_EN.
- When defined:
  - An 8-bit idle counter clears on entry to OPEN and on every non-idle edge.
  - The counter increments on each idle edge while in OPEN.
  - When it reaches RELOCK_CYCLES, st goes to 0 and unlc to 0 on that edge.
  - Reset clears the counter.
- When undefined: no counter is present, and OPEN persists indefinitely until a press, an invalid input or reset.

Test Plan:
- Reset: rst=0 held mid-sequence at st=2 -> st=0 and unlc=0 immediately, without waiting for a clock edge. The first edge after release starts from 0.
- Correct entry: presses 1,0,1,1 on consecutive edges -> st=1,2,3,4. unlc=1 on the 4th edge, then holds for 5 idle cycles.
- Overlap: presses 1,0,1,0,1,1 -> st=1,2,3,2,3,4, with unlc=1 only after the last edge. Presses 1,1 -> st=1,1.
- Relock from OPEN: after unlocking, press 0 -> st=2 and unlc=0. Then presses 1,1 -> st=4 and unlc=1.
- Invalid input: at st=3, b0=b1=1 -> st=0 and unlc=0. With both buttons idle, st holds its value.
- With ELECTRONIC_LOCK_AUTO_RELOCK_EN defined and RELOCK_CYCLES=8: unlock, then 7 idle cycles -> unlc still 1; the 8th idle cycle -> st=0, unlc=0. Without the macro: unlc is still 1 after 20 idle cycles.
